// File: rtl/traffic_ctrl.sv
// traffic_ctrl: three-phase traffic light sequencer with editable phase durations.
//
// Ports:
//   clk_div  in  1  single clock, one tick per cycle
//   rst      in  1  synchronous active-low reset
//   sw       in  2  mode: 00 RUN, 01 SET_Y, 10 SET_G, 11 SET_R
//   btn_inc  in  1  increment button (level, pre-synchronised)
//   btn_dec  in  1  decrement button (level, pre-synchronised)
//   led_r    out 4  current red duration
//   led_g    out 4  current green duration
//   led_y    out 4  current yellow duration
//   light    out 3  {red, yellow, green} one-hot lamp drive, 000 outside RUN
//   count    out 4  remaining ticks in the current phase
module traffic_ctrl #(
  parameter logic [3:0] DUR_G_RST = 4'd5,
  parameter logic [3:0] DUR_Y_RST = 4'd2,
  parameter logic [3:0] DUR_R_RST = 4'd4
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [3:0] led_r,
  output logic [3:0] led_g,
  output logic [3:0] led_y,
  output logic [2:0] light,
  output logic [3:0] count
);

  localparam logic [1:0] SW_RUN   = 2'b00;
  localparam logic [1:0] SW_SET_Y = 2'b01;
  localparam logic [1:0] SW_SET_G = 2'b10;
  localparam logic [1:0] SW_SET_R = 2'b11;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_RED    = 2'd2
  } state_t;

  // Durations live in 1..15; edits clamp at both ends.
  function automatic logic [3:0] sat_inc(input logic [3:0] d);
    sat_inc = (d == 4'd15) ? 4'd15 : d + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] d);
    sat_dec = (d <= 4'd1) ? 4'd1 : d - 4'd1;
  endfunction

  logic [3:0] r_dur_g;
  logic [3:0] r_dur_y;
  logic [3:0] r_dur_r;
  logic       r_inc_q;
  logic       r_dec_q;
  logic       r_armed;
  state_t     r_state;
  logic [3:0] r_count;

  logic w_run;
  logic w_inc_press;
  logic w_dec_press;
  logic w_inc_only;
  logic w_dec_only;

  assign w_run = (sw == SW_RUN);

  // r_armed is low only in the first cycle after reset, so a button held
  // through reset release is absorbed into the history register silently.
  assign w_inc_press = btn_inc & ~r_inc_q & r_armed;
  assign w_dec_press = btn_dec & ~r_dec_q & r_armed;
  assign w_inc_only  = w_inc_press & ~w_dec_press;
  assign w_dec_only  = w_dec_press & ~w_inc_press;

  // Button history and duration editing
  always_ff @(posedge clk_div) begin
    if (!rst) begin
      r_dur_g <= DUR_G_RST;
      r_dur_y <= DUR_Y_RST;
      r_dur_r <= DUR_R_RST;
      r_inc_q <= 1'b0;
      r_dec_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_inc_q <= btn_inc;
      r_dec_q <= btn_dec;
      r_armed <= 1'b1;
      case (sw)
        SW_SET_Y: begin
          if (w_inc_only)      r_dur_y <= sat_inc(r_dur_y);
          else if (w_dec_only) r_dur_y <= sat_dec(r_dur_y);
        end
        SW_SET_G: begin
          if (w_inc_only)      r_dur_g <= sat_inc(r_dur_g);
          else if (w_dec_only) r_dur_g <= sat_dec(r_dur_g);
        end
        SW_SET_R: begin
          if (w_inc_only)      r_dur_r <= sat_inc(r_dur_r);
          else if (w_dec_only) r_dur_r <= sat_dec(r_dur_r);
        end
        default: ;
      endcase
    end
  end

  // Phase FSM: SET modes park it in GREEN with a fresh green count every
  // cycle; in RUN a count of 1 (or an unexpected 0) advances the phase.
  always_ff @(posedge clk_div) begin
    if (!rst) begin
      r_state <= ST_GREEN;
      r_count <= DUR_G_RST;
    end else if (!w_run) begin
      r_state <= ST_GREEN;
      r_count <= r_dur_g;
    end else if (r_count > 4'd1) begin
      r_count <= r_count - 4'd1;
    end else begin
      case (r_state)
        ST_GREEN: begin
          r_state <= ST_YELLOW;
          r_count <= r_dur_y;
        end
        ST_YELLOW: begin
          r_state <= ST_RED;
          r_count <= r_dur_r;
        end
        ST_RED: begin
          r_state <= ST_GREEN;
          r_count <= r_dur_g;
        end
        default: begin
          r_state <= ST_GREEN;
          r_count <= r_dur_g;
        end
      endcase
    end
  end

  always_comb begin
    light = 3'b000;
    if (w_run) begin
      case (r_state)
        ST_GREEN:  light = 3'b001;
        ST_YELLOW: light = 3'b010;
        ST_RED:    light = 3'b100;
        default:   light = 3'b000;
      endcase
    end
  end

  assign led_g = r_dur_g;
  assign led_y = r_dur_y;
  assign led_r = r_dur_r;
  assign count = r_count;

endmodule

// File: tb/tb_traffic_ctrl.sv
module tb_traffic_ctrl;

  logic       clk_div = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic       btn_inc;
  logic       btn_dec;
  logic [3:0] led_r;
  logic [3:0] led_g;
  logic [3:0] led_y;
  logic [2:0] light;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  traffic_ctrl #(
    .DUR_G_RST(4'd5),
    .DUR_Y_RST(4'd2),
    .DUR_R_RST(4'd4)
  ) dut (
    .clk_div(clk_div),
    .rst    (rst),
    .sw     (sw),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .led_r  (led_r),
    .led_g  (led_g),
    .led_y  (led_y),
    .light  (light),
    .count  (count)
  );

  always #5 clk_div = ~clk_div;

  task automatic tick;
    @(posedge clk_div);
    #1;
  endtask

  // Reset edge plus one idle cycle so the first post-reset edge is consumed.
  task automatic do_reset;
    rst = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0; sw = 2'b00; btn_inc = 1'b0; btn_dec = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (led_g !== 4'd5) begin failures++; $display("FAIL reset_led_g: got %0d expected 5", led_g); end
    checks++; if (led_y !== 4'd2) begin failures++; $display("FAIL reset_led_y: got %0d expected 2", led_y); end
    checks++; if (led_r !== 4'd4) begin failures++; $display("FAIL reset_led_r: got %0d expected 4", led_r); end
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL reset_count: got %0d expected 5", count); end
    checks++; if (light !== 3'b001) begin failures++; $display("FAIL reset_light: got %b expected 001", light); end
  endtask

  // Must follow test_reset directly: cycle 1 is the cycle right after reset.
  task automatic test_run_sequence;
    logic [2:0] el;
    int         ec;
    int         pos;
    for (int c = 1; c <= 22; c++) begin
      pos = (c - 1) % 11;
      if (pos < 5)      begin el = 3'b001; ec = 5 - pos;  end
      else if (pos < 7) begin el = 3'b010; ec = 7 - pos;  end
      else              begin el = 3'b100; ec = 11 - pos; end
      checks++; if (light !== el) begin failures++; $display("FAIL run_light c%0d: got %b expected %b", c, light, el); end
      checks++; if (count !== ec) begin failures++; $display("FAIL run_count c%0d: got %0d expected %0d", c, count, ec); end
      tick();
    end
  endtask

  task automatic test_inc_dec;
    int eg;
    sw = 2'b10;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      btn_inc = 1'b1; tick();
      btn_inc = 1'b0; tick();
      eg = (5 + i > 15) ? 15 : 5 + i;
      checks++; if (led_g !== eg) begin failures++; $display("FAIL inc_led_g p%0d: got %0d expected %0d", i, led_g, eg); end
      checks++; if (count !== eg) begin failures++; $display("FAIL inc_count p%0d: got %0d expected %0d", i, count, eg); end
    end
    for (int i = 1; i <= 20; i++) begin
      btn_dec = 1'b1; tick();
      btn_dec = 1'b0; tick();
      eg = (15 - i < 1) ? 1 : 15 - i;
      checks++; if (led_g !== eg) begin failures++; $display("FAIL dec_led_g p%0d: got %0d expected %0d", i, led_g, eg); end
    end
    checks++; if (led_y !== 4'd2) begin failures++; $display("FAIL incdec_led_y: got %0d expected 2", led_y); end
    checks++; if (led_r !== 4'd4) begin failures++; $display("FAIL incdec_led_r: got %0d expected 4", led_r); end
    checks++; if (light !== 3'b000) begin failures++; $display("FAIL incdec_light: got %b expected 000", light); end
  endtask

  task automatic test_hold_and_both;
    sw = 2'b01;
    do_reset();
    btn_inc = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    btn_inc = 1'b0; tick();
    checks++; if (led_y !== 4'd3) begin failures++; $display("FAIL hold_led_y: got %0d expected 3", led_y); end
    btn_inc = 1'b1; btn_dec = 1'b1; tick();
    btn_inc = 1'b0; btn_dec = 1'b0; tick();
    checks++; if (led_y !== 4'd3) begin failures++; $display("FAIL both_led_y: got %0d expected 3", led_y); end
    checks++; if (led_g !== 4'd5) begin failures++; $display("FAIL both_led_g: got %0d expected 5", led_g); end
  endtask

  task automatic test_set_interrupt;
    sw = 2'b00;
    do_reset();
    // Now in run cycle 2; advance to cycle 10 (RED, count 2).
    for (int i = 0; i < 8; i++) tick();
    checks++; if (light !== 3'b100) begin failures++; $display("FAIL intr_pre_light: got %b expected 100", light); end
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL intr_pre_count: got %0d expected 2", count); end
    sw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (light !== 3'b000) begin failures++; $display("FAIL intr_set_light s%0d: got %b expected 000", i, light); end
      tick();
    end
    sw = 2'b00;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (light !== 3'b001) begin failures++; $display("FAIL intr_run_light r%0d: got %b expected 001", i, light); end
      checks++; if (count !== 5 - i) begin failures++; $display("FAIL intr_run_count r%0d: got %0d expected %0d", i, count, 5 - i); end
      tick();
    end
    checks++; if (led_r !== 4'd4) begin failures++; $display("FAIL intr_led_r: got %0d expected 4", led_r); end
  endtask

  task automatic test_run_ignore_and_short_yellow;
    logic [2:0] el;
    int         ec;
    sw = 2'b00;
    do_reset();
    btn_inc = 1'b1; tick(); btn_inc = 1'b0; tick();
    btn_dec = 1'b1; tick(); btn_dec = 1'b0; tick();
    checks++; if (led_g !== 4'd5) begin failures++; $display("FAIL ign_led_g: got %0d expected 5", led_g); end
    checks++; if (led_y !== 4'd2) begin failures++; $display("FAIL ign_led_y: got %0d expected 2", led_y); end
    checks++; if (led_r !== 4'd4) begin failures++; $display("FAIL ign_led_r: got %0d expected 4", led_r); end
    sw = 2'b01;
    btn_dec = 1'b1; tick(); btn_dec = 1'b0; tick();
    checks++; if (led_y !== 4'd1) begin failures++; $display("FAIL short_led_y: got %0d expected 1", led_y); end
    sw = 2'b00;
    #1;
    // G 5 cycles, Y 1 cycle, R 4 cycles, then G again.
    for (int c = 1; c <= 11; c++) begin
      if (c <= 5)       begin el = 3'b001; ec = 6 - c;  end
      else if (c == 6)  begin el = 3'b010; ec = 1;      end
      else if (c <= 10) begin el = 3'b100; ec = 11 - c; end
      else              begin el = 3'b001; ec = 5;      end
      checks++; if (light !== el) begin failures++; $display("FAIL short_light c%0d: got %b expected %b", c, light, el); end
      checks++; if (count !== ec) begin failures++; $display("FAIL short_count c%0d: got %0d expected %0d", c, count, ec); end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    sw = 2'b10;
    do_reset();
    btn_inc = 1'b1; tick(); btn_inc = 1'b0; tick();
    btn_inc = 1'b1; tick(); btn_inc = 1'b0; tick();
    sw = 2'b01;
    btn_inc = 1'b1; tick(); btn_inc = 1'b0; tick();
    checks++; if (led_g !== 4'd7) begin failures++; $display("FAIL mid_edit_g: got %0d expected 7", led_g); end
    checks++; if (led_y !== 4'd3) begin failures++; $display("FAIL mid_edit_y: got %0d expected 3", led_y); end
    sw = 2'b00;
    // Green lasts 7 cycles; run cycle 9 is mid-YELLOW.
    for (int i = 0; i < 8; i++) tick();
    checks++; if (light !== 3'b010) begin failures++; $display("FAIL mid_pre_light: got %b expected 010", light); end
    rst = 1'b0; btn_inc = 1'b1; sw = 2'b10;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (led_g !== 4'd5) begin failures++; $display("FAIL mid_rst_g: got %0d expected 5", led_g); end
    checks++; if (led_y !== 4'd2) begin failures++; $display("FAIL mid_rst_y: got %0d expected 2", led_y); end
    checks++; if (led_r !== 4'd4) begin failures++; $display("FAIL mid_rst_r: got %0d expected 4", led_r); end
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL mid_rst_count: got %0d expected 5", count); end
    tick();
    tick();
    checks++; if (led_g !== 4'd5) begin failures++; $display("FAIL mid_release_g: got %0d expected 5", led_g); end
    btn_inc = 1'b0; sw = 2'b00;
    #1;
    checks++; if (light !== 3'b001) begin failures++; $display("FAIL mid_run_light: got %b expected 001", light); end
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL mid_run_count: got %0d expected 5", count); end
  endtask

  initial begin
    rst = 1'b0; sw = 2'b00; btn_inc = 1'b0; btn_dec = 1'b0;
    test_reset();
    test_run_sequence();
    test_inc_dec();
    test_hold_and_both();
    test_set_interrupt();
    test_run_ignore_and_short_yellow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
